dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: latches one request, answers after LATENCY cycles.
// Optional build macro DMEM_CLEAR_ON_RST_EN: when defined, reset also zeroes the whole data array.
module dmem_responder #(
   parameter int unsigned LATENCY   = 3,
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        freeze
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic [31:0] mem_q [DEPTH];

   logic        req;
   logic [31:0] rd_addr;
   logic        rd_sel;
   logic        mem_we;

   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < DEPTH);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
      return IW'((a - BASE_ADDR) >> 2);
   endfunction

   assign req = MEM_R_EN | MEM_W_EN;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      rd_addr = addr_q;
      rd_sel  = rd_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = address;
               wdata_d = wdata;
               wr_d    = MEM_W_EN;
               rd_d    = MEM_R_EN & ~MEM_W_EN;
               // LATENCY=1 reaches DONE on the accepting edge, so the read uses the live inputs
               rd_addr = address;
               rd_sel  = MEM_R_EN & ~MEM_W_EN;
               if (LATENCY <= 1) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  state_d = BUSY;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == DONE);
      rdata_d = rdata_q;
      if (state_d == DONE && rd_sel) begin
         rdata_d = in_range(rd_addr) ? mem_q[word_idx(rd_addr)] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
      end
   end

   // Store commits on the edge leaving DONE; a reset on that edge drops it.
   assign mem_we = !rst && (state_q == DONE) && wr_q && in_range(addr_q);

`ifdef DMEM_CLEAR_ON_RST_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[word_idx(addr_q)] <= wdata_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[word_idx(addr_q)] <= wdata_q;
      end
   end
`endif

   assign rdata  = rdata_q;
   assign ready  = ready_q;
   assign freeze = rst ? req : ((state_q == IDLE && req) || state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=3 instance and a LATENCY=1 instance against a transaction-level model.
module tb_dmem_responder;

   logic             clk = 1'b0;
   logic [1:0]       rst_v, ren, wen, rdy_v, frz_v;
   logic [1:0][31:0] addr_v, wd_v, rdata_v;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(3), .DEPTH(64), .BASE_ADDR(32'd1024)) u_a (
      .clk(clk), .rst(rst_v[0]), .MEM_R_EN(ren[0]), .MEM_W_EN(wen[0]),
      .address(addr_v[0]), .wdata(wd_v[0]), .rdata(rdata_v[0]),
      .ready(rdy_v[0]), .freeze(frz_v[0]));

   dmem_responder #(.LATENCY(1), .DEPTH(16), .BASE_ADDR(32'd256)) u_b (
      .clk(clk), .rst(rst_v[1]), .MEM_R_EN(ren[1]), .MEM_W_EN(wen[1]),
      .address(addr_v[1]), .wdata(wd_v[1]), .rdata(rdata_v[1]),
      .ready(rdy_v[1]), .freeze(frz_v[1]));

   // Transaction-level reference: a request completes LATENCY edges after acceptance,
   // then a one-cycle completion slot during which stores are committed.
   int          lat  [2] = '{3, 1};
   int          dep  [2] = '{64, 16};
   longint      base [2] = '{1024, 256};
   bit          m_pend [2];
   bit          m_rdy  [2];
   bit          m_wr   [2];
   bit          m_rd   [2];
   int          m_left [2];
   logic [31:0] m_a    [2];
   logic [31:0] m_d    [2];
   logic [31:0] m_rdata[2];
   logic [31:0] m_mem  [2][64];
   logic [31:0] initv  [2][64];
   bit          chk_en = 1'b0;

   function automatic bit m_inr(input int k, input logic [31:0] a);
      longint la = longint'(a);
      return (la >= base[k]) && ((la - base[k]) / 4 < dep[k]);
   endfunction

   function automatic int m_idx(input int k, input logic [31:0] a);
      longint la = longint'(a);
      return int'((la - base[k]) / 4);
   endfunction

   task automatic m_complete(input int k);
      m_rdy[k]  = 1'b1;
      m_pend[k] = 1'b0;
      if (m_rd[k]) m_rdata[k] = m_inr(k, m_a[k]) ? m_mem[k][m_idx(k, m_a[k])] : 32'h0;
   endtask

   task automatic m_edge(input int k);
      if (rst_v[k]) begin
         m_pend[k]  = 1'b0;
         m_rdy[k]   = 1'b0;
         m_rdata[k] = 32'h0;
`ifdef DMEM_CLEAR_ON_RST_EN
         for (int i = 0; i < 64; i++) m_mem[k][i] = 32'h0;
`endif
      end else if (m_rdy[k]) begin
         if (m_wr[k] && m_inr(k, m_a[k])) m_mem[k][m_idx(k, m_a[k])] = m_d[k];
         m_rdy[k] = 1'b0;
      end else if (m_pend[k]) begin
         m_left[k]--;
         if (m_left[k] == 0) m_complete(k);
      end else if (ren[k] || wen[k]) begin
         m_wr[k]   = wen[k];
         m_rd[k]   = ren[k] && !wen[k];
         m_a[k]    = addr_v[k];
         m_d[k]    = wd_v[k];
         m_left[k] = lat[k] - 1;
         if (m_left[k] == 0) m_complete(k);
         else m_pend[k] = 1'b1;
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drv(input int k, input bit r_, input bit rd_, input bit wr_,
                      input logic [31:0] a_, input logic [31:0] d_);
      rst_v[k]  = r_;
      ren[k]    = rd_;
      wen[k]    = wr_;
      addr_v[k] = a_;
      wd_v[k]   = d_;
   endtask

   // Called just after a negedge with inputs applied; returns at the next negedge.
   task automatic tick();
      bit ef;
      #1;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            ef = rst_v[k] ? (ren[k] | wen[k]) :
                 m_pend[k] ? 1'b1 : m_rdy[k] ? 1'b0 : (ren[k] | wen[k]);
            check($sformatf("model_freeze[%0d]", k), 32'(frz_v[k]), 32'(ef));
            check($sformatf("model_ready[%0d]", k), 32'(rdy_v[k]), 32'(m_rdy[k]));
            check($sformatf("model_rdata[%0d]", k), rdata_v[k], m_rdata[k]);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) m_edge(k);
      @(negedge clk);
   endtask

   typedef struct {
      bit          rst, r, w;
      logic [31:0] a, d;
      bit          f, rdy;
      logic [31:0] rd;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit rs, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit f, input bit rdy, input logic [31:0] rd);
      vec_t v;
      v.rst = rs; v.r = r; v.w = w; v.a = a; v.d = d; v.f = f; v.rdy = rdy; v.rd = rd;
      tbl.push_back(v);
   endtask

   initial begin
      logic [31:0] exp_old;
      // rows: rst, r, w, address, wdata | freeze, ready, rdata  (instance with LATENCY=3)
      add(1, 0, 0, 0,     0,            0, 0, 32'h0);
      add(0, 0, 1, 1028,  32'h12345678, 1, 0, 32'h0);
      add(0, 1, 0, 1100,  0,            1, 0, 32'h0);
      add(0, 0, 1, 1032,  32'hFFFFFFFF, 1, 0, 32'h0);
      add(0, 0, 1, 1036,  32'h11111111, 0, 1, 32'h0);
      add(0, 1, 0, 1028,  0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 1, 0, 1031,  0,            0, 1, 32'h12345678);
      add(0, 1, 0, 1031,  0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            1, 0, 32'h12345678);
      add(0, 0, 1, 1020,  32'hDEADBEEF, 0, 1, 32'h12345678);
      add(0, 0, 1, 1020,  32'hDEADBEEF, 1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            0, 1, 32'h12345678);
      add(0, 1, 0, 1020,  0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            1, 0, 32'h12345678);
      add(0, 0, 0, 0,     0,            0, 1, 32'h0);
      add(0, 1, 0, 1280,  0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            0, 1, 32'h0);
      add(0, 1, 1, 1028,  32'hA5A5A5A5, 1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            0, 1, 32'h0);
      add(0, 1, 0, 1028,  0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            1, 0, 32'h0);
      add(0, 0, 0, 0,     0,            0, 1, 32'hA5A5A5A5);
      add(0, 1, 0, 1023,  0,            1, 0, 32'hA5A5A5A5);
      add(0, 0, 0, 0,     0,            1, 0, 32'hA5A5A5A5);
      add(0, 0, 0, 0,     0,            1, 0, 32'hA5A5A5A5);
      add(0, 0, 0, 0,     0,            0, 1, 32'h0);

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) initv[k][i] = $urandom;

      @(negedge clk);
      drv(0, 1, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 0);
      tick();
      tick();
      drv(0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset_ready[%0d]", k), 32'(rdy_v[k]), 32'h0);
         check($sformatf("reset_rdata[%0d]", k), rdata_v[k], 32'h0);
         check($sformatf("reset_freeze[%0d]", k), 32'(frz_v[k]), 32'h0);
      end
      chk_en = 1'b1;

      // Fill both arrays through the DUT so every word is known to the model.
      for (int i = 0; i < 64; i++) begin
         drv(0, 0, 0, 1, 32'(1024 + 4 * i), initv[0][i]);
         if (i < 16) drv(1, 0, 0, 1, 32'(256 + 4 * i), initv[1][i]);
         else        drv(1, 0, 0, 0, 0, 0);
         tick();
         drv(0, 0, 0, 0, 0, 0);
         drv(1, 0, 0, 0, 0, 0);
         tick(); tick(); tick();
      end

      foreach (tbl[i]) begin
         drv(0, tbl[i].rst, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
         drv(1, 0, 0, 0, 0, 0);
         #1;
         check($sformatf("vec%0d_freeze", i), 32'(frz_v[0]), 32'(tbl[i].f));
         check($sformatf("vec%0d_ready", i), 32'(rdy_v[0]), 32'(tbl[i].rdy));
         check($sformatf("vec%0d_rdata", i), rdata_v[0], tbl[i].rd);
         tick();
      end

      // Reset in the middle of a store: request aborted, store discarded.
`ifdef DMEM_CLEAR_ON_RST_EN
      exp_old = 32'h0;
`else
      exp_old = initv[0][2];
`endif
      drv(0, 0, 0, 1, 1032, 32'h0BADF00D);
      tick();
      drv(0, 1, 1, 0, 1040, 0);
      #1;
      check("rst_busy_freeze", 32'(frz_v[0]), 32'h1);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      #1;
      check("rst_after_freeze", 32'(frz_v[0]), 32'h0);
      check("rst_after_ready", 32'(rdy_v[0]), 32'h0);
      check("rst_after_rdata", rdata_v[0], 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("rst_no_ready%0d", i), 32'(rdy_v[0]), 32'h0);
         tick();
      end
      drv(0, 0, 1, 0, 1032, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      tick(); tick();
      #1;
      check("rst_read_ready", 32'(rdy_v[0]), 32'h1);
      check("rst_read_rdata", rdata_v[0], exp_old);
      tick();

      // LATENCY=1 with a read held high: accept/complete alternate.
      for (int i = 0; i < 8; i++) begin
         drv(1, 0, 1, 0, 32'(256 + 20), 0);
         #1;
         check($sformatf("b2b_freeze%0d", i), 32'(frz_v[1]), 32'((i % 2) == 0));
         check($sformatf("b2b_ready%0d", i), 32'(rdy_v[1]), 32'((i % 2) == 1));
         check($sformatf("b2b_rdata%0d", i), rdata_v[1], (i == 0) ? 32'h0 : initv[1][5]);
         tick();
      end
      drv(1, 0, 0, 0, 0, 0);
      tick();

      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < 2; k++) begin
            int unsigned rnd, sel;
            logic [31:0] a;
            rnd = $urandom_range(0, 9);
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'(base[k] + 4 * $urandom_range(0, dep[k] - 1) + $urandom_range(0, 3));
            else if (sel == 7) a = 32'(base[k] - 1 - $urandom_range(0, 7));
            else if (sel == 8) a = 32'(base[k] + 4 * dep[k] + $urandom_range(0, 15));
            else               a = $urandom;
            drv(k, $urandom_range(0, 59) == 0, rnd < 4, rnd >= 3 && rnd < 7, a, $urandom);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
